ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register for the RV32I core. Sits directly upstream of the ALU and drives its a, b and 4-bit op inputs.
- Registers the decoded instruction fields and translates funct3/funct7[5] into the ALU op code.
- Resolves EX/MEM and MEM/WB forwarding for both operands, masks shift amounts, and detects load-use hazards.

Parameters:
XLEN, 32, datapath width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold the stage register
flush  in  1  replace the stage contents with a bubble
id_valid  in  1  decode slot holds an instruction
id_pc  in  XLEN  PC of the decoding instruction
id_rs1_val, id_rs2_val  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  5  register indices
id_funct3  in  3  instruction funct3
id_funct7b5  in  1  instruction bit 30
id_alu_mode  in  2  00 force ADD, 01 R-type, 10 I-type ALU, 11 force SUB (branch)
id_a_sel  in  1  0 = rs1, 1 = PC
id_b_sel  in  1  0 = rs2, 1 = imm
id_reg_write, id_is_load  in  1  control bits
exm_rd, wb_rd  in  5  destination register of the EX/MEM and MEM/WB stages
exm_reg_write, wb_reg_write  in  1  write enables of those stages
exm_result, wb_result  in  XLEN  forwarding data
ex_valid  out  1  stage holds a live instruction
alu_a, alu_b  out  XLEN  ALU operands
alu_op  out  4  ALU op
ex_store_data  out  XLEN  forwarded rs2 value
ex_pc  out  XLEN  registered PC
ex_rd  out  5  registered rd
ex_reg_write, ex_is_load  out  1  registered control bits
load_use_hazard  out  1  combinational; upstream must stall

Behaviour:
- Register update each rising clk, first match wins:
  - rst: all fields 0.
  - flush: bubble, i.e. all fields 0.
  - stall: hold all fields.
  - load_use_hazard: bubble.
  - otherwise: capture the id_* inputs.
- A captured instruction with id_valid=0 also forces reg_write=0 and is_load=0.
- Reset state: ex_valid=0, alu_op=0 (ADD), alu_a=0, alu_b=0, ex_rd=0, ex_reg_write=0, ex_is_load=0, ex_store_data=0, ex_pc=0. A stored rs index of 0 disables forwarding.
- alu_op decode at capture:
  - Mode 00: op 0.
  - Mode 11: op 9.
  - Modes 01/10, by funct3:
    - 000: op 9 if mode 01 and f7b5=1, else op 0.
    - 001: op 1.
    - 010: op 2.
    - 011: op 3.
    - 100: op 4.
    - 101: op 6 if f7b5=1, else op 5.
    - 110: op 7.
    - 111: op 8.
- Forwarding is combinational from the registered rsN and the current-cycle forward buses:
  - EX/MEM wins if exm_reg_write, exm_rd != 0 and exm_rd == rsN.
  - Otherwise MEM/WB wins if wb_reg_write, wb_rd != 0 and wb_rd == rsN.
  - Otherwise the registered rsN value is used.
- Operand selection:
  - alu_a = a_sel ? ex_pc : fwd_rs1.
  - b_raw = b_sel ? imm : fwd_rs2.
  - For alu_op 1, 5 or 6: alu_b = {27'b0, b_raw[4:0]}; otherwise alu_b = b_raw.
- ex_store_data = fwd_rs2, regardless of b_sel.
- load_use_hazard = ex_valid & ex_is_load & ex_rd != 0 & id_valid & ((id_a_sel==0 & id_rs1==ex_rd) | id_rs2==ex_rd).
  - The rs2 compare is intentionally conservative.
  - The signal is independent of stall. When it is asserted while stall=0, a bubble is inserted and the ID instruction is retried next cycle.
- Simultaneous flush and stall: flush wins.
- Reset mid-stall: reset wins.
- Single-cycle stage: an instruction captured at edge N presents its ALU inputs during cycle N+1.

Test Plan:
- Reset, then R-type SUB capture: rst=1 for 2 cycles -> all outputs 0. Then capture mode 01, funct3 000, f7b5 1, rs1_val=10, rs2_val=3 -> next cycle alu_op=9, alu_a=10, alu_b=3, ex_valid=1.
- Shift masking and SRAI: mode 10, funct3 101, f7b5 1, imm=0x0000_0423 -> alu_op=6, alu_b=0x3. A mode-10 ADDI with the same imm gives alu_b=0x423.
- Forward priority: registered rs1=5; exm_rd=5 with exm_result=0xAAAA; wb_rd=5 with wb_result=0xBBBB -> alu_a=0xAAAA. Drop exm_reg_write -> 0xBBBB. Set rs1=0 -> no forward, alu_a equals the stored value.
- Load-use: EX holds a load with rd=7; ID presents rs2=7, id_valid=1 -> load_use_hazard=1 and next cycle ex_valid=0, ex_reg_write=0. With rd=0 instead -> no hazard.
- Stall/flush: stall=1 for 3 cycles -> outputs frozen. stall=1 and flush=1 together -> bubble (ex_valid=0, alu_op=0).
- Full decode sweep: all funct3 values × f7b5 × modes 01/10 -> alu_op matches the decode rules. Mode 11 -> 9 for any funct3.

Source files
------------

// File: rtl/ex_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ex_operand_stage                                              |
// | Purpose  : ID/EX pipeline register for the RV32I core. Captures decoded  |
// |            fields, derives the ALU op, resolves EX/MEM and MEM/WB        |
// |            forwarding, masks shift amounts and flags load-use hazards.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [1:0]      id_alu_mode,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic [4:0]      exm_rd,
  input  logic [4:0]      wb_rd,
  input  logic            exm_reg_write,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic            load_use_hazard
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_REG = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b11;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;

  // Stage storage
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [4:0]      rs1, rs2;
  logic            a_sel, b_sel;
  logic [3:0]      next_op;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, b_raw;

  // ALU op decode from the instruction in the decode slot
  always_comb begin
    next_op = OP_ADD;
    if (id_alu_mode == MODE_SUB) begin
      next_op = OP_SUB;
    end else if (id_alu_mode != MODE_ADD) begin
      case (id_funct3)
        3'b000:  next_op = (id_alu_mode == MODE_REG && id_funct7b5) ? OP_SUB : OP_ADD;
        3'b001:  next_op = OP_SLL;
        3'b010:  next_op = OP_SLT;
        3'b011:  next_op = OP_SLTU;
        3'b100:  next_op = OP_XOR;
        3'b101:  next_op = id_funct7b5 ? OP_SRA : OP_SRL;
        3'b110:  next_op = OP_OR;
        default: next_op = OP_AND;
      endcase
    end
  end

  // A load in EX whose rd is needed by the decoding instruction; rs2 is
  // compared even when the instruction uses the immediate (conservative).
  assign load_use_hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                           (((~id_a_sel) & (id_rs1 == ex_rd)) | (id_rs2 == ex_rd));

  // Stage register: reset, flush, stall, hazard bubble, then capture
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && load_use_hazard)) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_val      <= '0;
      rs2_val      <= '0;
      imm          <= '0;
      rs1          <= '0;
      rs2          <= '0;
      ex_rd        <= '0;
      alu_op       <= OP_ADD;
      a_sel        <= 1'b0;
      b_sel        <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      rs1_val      <= id_rs1_val;
      rs2_val      <= id_rs2_val;
      imm          <= id_imm;
      rs1          <= id_rs1;
      rs2          <= id_rs2;
      ex_rd        <= id_rd;
      alu_op       <= next_op;
      a_sel        <= id_a_sel;
      b_sel        <= id_b_sel;
      ex_reg_write <= id_reg_write & id_valid;
      ex_is_load   <= id_is_load & id_valid;
    end
  end

  // Operand forwarding: the younger EX/MEM result takes priority over MEM/WB
  always_comb begin
    fwd_rs1 = rs1_val;
    if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs1)
      fwd_rs1 = exm_result;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs1)
      fwd_rs1 = wb_result;

    fwd_rs2 = rs2_val;
    if (exm_reg_write && exm_rd != 5'd0 && exm_rd == rs2)
      fwd_rs2 = exm_result;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs2)
      fwd_rs2 = wb_result;
  end

  // Operand muxing; shift ops only see the low five bits of b
  always_comb begin
    alu_a = a_sel ? ex_pc : fwd_rs1;
    b_raw = b_sel ? imm : fwd_rs2;
    if (alu_op == OP_SLL || alu_op == OP_SRL || alu_op == OP_SRA)
      alu_b = {{(XLEN-5){1'b0}}, b_raw[4:0]};
    else
      alu_b = b_raw;
  end

  assign ex_store_data = fwd_rs2;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ex_operand_stage                                           |
// | Purpose  : Self-checking bench for ex_operand_stage with directed steps  |
// |            and randomized traffic against a behavioural model.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ex_operand_stage;

  logic        clk, rst, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [1:0]  id_alu_mode;
  logic        id_a_sel, id_b_sel, id_reg_write, id_is_load;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_reg_write, wb_reg_write;
  logic [31:0] exm_result, wb_result;
  logic        ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_load, load_use_hazard;

  int n_cmp = 0;
  int n_err = 0;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_alu_mode(id_alu_mode),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .exm_rd(exm_rd), .wb_rd(wb_rd),
    .exm_reg_write(exm_reg_write), .wb_reg_write(wb_reg_write),
    .exm_result(exm_result), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .load_use_hazard(load_use_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction currently held in EX
  logic        m_valid, m_asel, m_bsel, m_rw, m_ld;
  logic [31:0] m_pc, m_rs1v, m_rs2v, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;

  // funct3 -> op for the non-special encodings (ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND)
  int unsigned op_table [8] = '{0, 1, 2, 3, 4, 5, 7, 8};

  function automatic logic [3:0] exp_op(logic [1:0] mode, logic [2:0] f3, logic f7);
    if (mode == 2'd0) return 4'd0;
    if (mode == 2'd3) return 4'd9;
    if (f3 == 3'd0 && mode == 2'd1 && f7) return 4'd9;
    if (f3 == 3'd5 && f7) return 4'd6;
    return 4'(op_table[f3]);
  endfunction

  function automatic logic [31:0] exp_fwd(logic [4:0] rs, logic [31:0] val);
    if (exm_reg_write && exm_rd != 0 && exm_rd == rs) return exm_result;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_result;
    return val;
  endfunction

  function automatic logic exp_hazard();
    return m_valid && m_ld && m_rd != 0 && id_valid &&
           ((!id_a_sel && id_rs1 == m_rd) || id_rs2 == m_rd);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] b;
    b = m_bsel ? m_imm : exp_fwd(m_rs2, m_rs2v);
    if (m_op == 4'd1 || m_op == 4'd5 || m_op == 4'd6) b = b % 32;
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".op"},    32'(alu_op), 32'(m_op));
    chk({tag, ".a"},     alu_a, m_asel ? m_pc : exp_fwd(m_rs1, m_rs1v));
    chk({tag, ".b"},     alu_b, b);
    chk({tag, ".sd"},    ex_store_data, exp_fwd(m_rs2, m_rs2v));
    chk({tag, ".pc"},    ex_pc, m_pc);
    chk({tag, ".rd"},    32'(ex_rd), 32'(m_rd));
    chk({tag, ".rw"},    32'(ex_reg_write), 32'(m_rw));
    chk({tag, ".ld"},    32'(ex_is_load), 32'(m_ld));
    chk({tag, ".luh"},   32'(load_use_hazard), 32'(exp_hazard()));
  endtask

  task automatic model_zero();
    {m_valid, m_asel, m_bsel, m_rw, m_ld} = '0;
    {m_pc, m_rs1v, m_rs2v, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_op} = '0;
  endtask

  // One clock edge: advance the model from pre-edge inputs, then check
  task automatic tick(string tag);
    logic hz;
    hz = exp_hazard();
    @(posedge clk);
    if (rst || flush || (!stall && hz)) begin
      model_zero();
    end else if (!stall) begin
      m_valid = id_valid;
      m_pc = id_pc; m_rs1v = id_rs1_val; m_rs2v = id_rs2_val; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_op = exp_op(id_alu_mode, id_funct3, id_funct7b5);
      m_asel = id_a_sel; m_bsel = id_b_sel;
      m_rw = id_reg_write && id_valid;
      m_ld = id_is_load && id_valid;
    end
    #1;
    check_all(tag);
  endtask

  task automatic clear_id();
    id_valid = 1'b1; id_pc = 32'h100; id_rs1_val = 0; id_rs2_val = 0; id_imm = 0;
    id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_funct3 = 0; id_funct7b5 = 0;
    id_alu_mode = 2'd1; id_a_sel = 0; id_b_sel = 0; id_reg_write = 1; id_is_load = 0;
    exm_rd = 0; wb_rd = 0; exm_reg_write = 0; wb_reg_write = 0;
    exm_result = 0; wb_result = 0;
  endtask

  initial begin
    logic [31:0] held_a, held_pc;
    rst = 1; stall = 0; flush = 0;
    clear_id();
    model_zero();

    // Reset for two cycles
    tick("rst0");
    tick("rst1");
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_a", alu_a, 0);
    rst = 0;

    // R-type SUB
    id_funct7b5 = 1; id_rs1_val = 10; id_rs2_val = 3;
    tick("sub");
    chk("sub_op", 32'(alu_op), 9);
    chk("sub_a", alu_a, 10);
    chk("sub_b", alu_b, 3);

    // SRAI masks the shift amount; ADDI keeps the full immediate
    clear_id(); id_alu_mode = 2'd2; id_funct3 = 3'd5; id_funct7b5 = 1;
    id_b_sel = 1; id_imm = 32'h0000_0423;
    tick("srai");
    chk("srai_op", 32'(alu_op), 6);
    chk("srai_b", alu_b, 32'h3);
    id_funct3 = 3'd0; id_funct7b5 = 0;
    tick("addi");
    chk("addi_b", alu_b, 32'h423);

    // Forwarding priority
    clear_id(); id_rs1 = 5; id_rs2 = 6; id_rs1_val = 32'h1234;
    tick("fwd_cap");
    exm_rd = 5; exm_reg_write = 1; exm_result = 32'hAAAA;
    wb_rd = 5; wb_reg_write = 1; wb_result = 32'hBBBB;
    #1; check_all("fwd_both");
    chk("fwd_exm", alu_a, 32'hAAAA);
    exm_reg_write = 0;
    #1; check_all("fwd_wb");
    chk("fwd_wb_a", alu_a, 32'hBBBB);
    id_rs1 = 0; id_rs1_val = 32'h5555;
    exm_rd = 0; wb_rd = 0; exm_reg_write = 1;
    tick("fwd_x0");
    chk("fwd_x0_a", alu_a, 32'h5555);

    // Load-use hazard on rs2
    clear_id(); id_alu_mode = 2'd0; id_b_sel = 1; id_rd = 7; id_is_load = 1;
    tick("ld_cap");
    id_is_load = 0; id_rd = 8; id_rs1 = 3; id_rs2 = 7; id_b_sel = 0;
    #1; chk("luh_on", 32'(load_use_hazard), 1);
    tick("luh_bub");
    chk("luh_valid", 32'(ex_valid), 0);
    chk("luh_rw", 32'(ex_reg_write), 0);
    tick("luh_retry");
    clear_id(); id_rd = 0; id_is_load = 1;
    tick("ld0_cap");
    id_is_load = 0; id_rs2 = 0; id_rs1 = 0;
    #1; chk("luh_rd0", 32'(load_use_hazard), 0);

    // Stall holds, stall+flush bubbles
    clear_id(); id_rs1_val = 32'hCAFE; id_pc = 32'h2000; id_funct3 = 3'd7;
    tick("st_cap");
    held_a = alu_a; held_pc = ex_pc;
    stall = 1; id_rs1_val = 32'h1; id_pc = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_a", alu_a, held_a);
      chk("stall_pc", ex_pc, held_pc);
    end
    flush = 1;
    tick("st_fl");
    chk("stfl_valid", 32'(ex_valid), 0);
    chk("stfl_op", 32'(alu_op), 0);
    stall = 0; flush = 0;

    // Decode sweep
    clear_id();
    for (int m = 1; m <= 3; m++)
      for (int f = 0; f < 8; f++)
        for (int s = 0; s < 2; s++) begin
          id_alu_mode = 2'(m); id_funct3 = 3'(f); id_funct7b5 = s[0];
          tick("sweep");
        end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 14) == 0);
      stall = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_pc = $urandom; id_rs1_val = $urandom; id_rs2_val = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
      id_alu_mode = 2'($urandom); id_a_sel = 1'($urandom); id_b_sel = 1'($urandom);
      id_reg_write = 1'($urandom); id_is_load = ($urandom_range(0, 2) == 0);
      exm_rd = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7));
      exm_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      exm_result = $urandom; wb_result = $urandom;
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
